// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: ImmSrc encodings, base opcodes and the
// immediate-queue entry layout. No logic, no latency, no flow control.
package riscv_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  immsrc;
    logic        has_imm;
    logic        illegal;
  } imm_entry_t;

endpackage

// File: rtl/extend.sv
// Immediate extend unit: rebuilds the sign-extended immediate for the selected
// format. Purely combinational, zero latency, no flow control.
module extend
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [2:0]  immsrc,
  output logic [31:0] immext
);

  always_comb begin
    case (immsrc)
      IMM_I:   immext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   immext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   immext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   immext = {instr[31:12], 12'h000};
      default: immext = 32'h0;
    endcase
  end

endmodule

// File: rtl/imm_decode_sched.sv
// Decode-stage immediate scheduler: classifies opcodes, extends immediates and queues them
// in a 2-entry skid FIFO; 1-cycle latency, in_ready drops only when both entries are full.
module imm_decode_sched
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_immsrc,
  output logic             out_has_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] imm_count
);

  logic [2:0]  dec_immsrc;
  logic        dec_has_imm;
  logic        dec_illegal;
  logic [31:0] imm_ext;
  imm_entry_t  new_entry;
  imm_entry_t  head;

  imm_entry_t       mem_q [2];
  imm_entry_t       mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] imm_count_q, imm_count_d;

  logic push;
  logic pop;

  always_comb begin
    dec_immsrc  = IMM_I;
    dec_has_imm = 1'b1;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: dec_immsrc = IMM_I;
      OP_STORE:                 dec_immsrc = IMM_S;
      OP_BRANCH:                dec_immsrc = IMM_B;
      OP_JAL:                   dec_immsrc = IMM_J;
      OP_LUI, OP_AUIPC:         dec_immsrc = IMM_U;
      OP_R:                     dec_has_imm = 1'b0;
      default: begin
        dec_has_imm = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  extend u_extend (
    .instr  (in_instr[31:7]),
    .immsrc (dec_immsrc),
    .immext (imm_ext)
  );

  always_comb begin
    new_entry.imm     = dec_has_imm ? imm_ext : 32'h0;
    new_entry.immsrc  = dec_immsrc;
    new_entry.has_imm = dec_has_imm;
    new_entry.illegal = dec_illegal;
  end

  // in_ready comes from registered occupancy only, so it never depends on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign head      = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    imm_count_d = imm_count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        if (head.has_imm && (imm_count_q != {CNT_W{1'b1}})) begin
          imm_count_d = imm_count_q + CNT_W'(1);
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      imm_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      imm_count_q <= imm_count_d;
    end
  end

  assign out_imm     = head.imm;
  assign out_immsrc  = head.immsrc;
  assign out_has_imm = head.has_imm;
  assign out_illegal = head.illegal;
  assign imm_count   = imm_count_q;

endmodule

// File: tb/tb_imm_decode_sched.sv
// Bench for imm_decode_sched: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed values and a CNT_W=2 saturation instance.
module tb_imm_decode_sched;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_immsrc;
  logic        out_has_imm;
  logic        out_illegal;
  logic [15:0] imm_count;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_instr;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_imm;
  logic [2:0]  s_out_immsrc;
  logic        s_out_has_imm;
  logic        s_out_illegal;
  logic [1:0]  s_imm_count;

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  imm_decode_sched #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_immsrc(out_immsrc), .out_has_imm(out_has_imm),
    .out_illegal(out_illegal), .imm_count(imm_count)
  );

  imm_decode_sched #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .flush(1'b0), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_imm(s_out_imm), .out_immsrc(s_out_immsrc), .out_has_imm(s_out_has_imm),
    .out_illegal(s_out_illegal), .imm_count(s_imm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of decoded entries.
  typedef struct {
    logic [31:0] imm;
    int          fmt;
    bit          has;
    bit          ill;
  } exp_t;

  exp_t mq[$];
  int   m_cnt;
  bit   pristine;

  function automatic exp_t model_decode(input logic [31:0] w);
    exp_t e;
    int   v;
    e.fmt = 0; e.has = 1; e.ill = 0; v = 0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: e.fmt = 0;
      7'h23: e.fmt = 1;
      7'h63: e.fmt = 2;
      7'h6F: e.fmt = 3;
      7'h37, 7'h17: e.fmt = 4;
      7'h33: e.has = 0;
      default: begin e.has = 0; e.ill = 1; end
    endcase
    case (e.fmt)
      0: begin v = int'(w[31:20]); if (w[31]) v -= 4096; end
      1: begin v = int'(w[31:25]) * 32 + int'(w[11:7]); if (w[31]) v -= 4096; end
      2: begin
        v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) v -= 4096;
      end
      3: begin
        v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) v -= 1048576;
      end
      default: v = int'(w[31:12]) << 12;
    endcase
    e.imm = e.has ? 32'(v) : 32'h0;
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_cnt    = 0;
      pristine = 1;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (mq.size() < 2);
      do_pop  = out_ready && (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) begin
          if (mq[0].has && m_cnt < 65535) m_cnt++;
          void'(mq.pop_front());
        end
        if (do_push) begin
          mq.push_back(model_decode(in_instr));
          pristine = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, mq.size() != 2});
      chk("m_imm_count", {16'b0, imm_count}, 32'(m_cnt));
      if (mq.size() != 0) begin
        chk("m_out_imm", out_imm, mq[0].imm);
        chk("m_out_immsrc", {29'b0, out_immsrc}, 32'(mq[0].fmt));
        chk("m_out_has_imm", {31'b0, out_has_imm}, {31'b0, mq[0].has});
        chk("m_out_illegal", {31'b0, out_illegal}, {31'b0, mq[0].ill});
      end else if (pristine) begin
        chk("m_reset_heads", {out_imm[28:0], out_immsrc}, 32'h0);
        chk("m_reset_flags", {30'b0, out_has_imm, out_illegal}, 32'h0);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream [10];

  initial begin
    stream[0] = 32'hFFF00093; stream[1] = 32'h00112623; stream[2] = 32'hFE000EE3;
    stream[3] = 32'h008000EF; stream[4] = 32'h123452B7; stream[5] = 32'h002081B3;
    stream[6] = 32'h00001517; stream[7] = 32'h00812083; stream[8] = 32'h000080E7;
    stream[9] = 32'h40208133;

    reset_n = 1; in_valid = 0; in_instr = 0; flush = 0; out_ready = 0;
    s_in_valid = 0; s_in_instr = 0; s_out_ready = 0;
    #1 reset_n = 0;
    #1 run = 1;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_imm_count", {16'b0, imm_count}, 32'd0);
    step(); step();
    reset_n = 1;
    step();

    // Single I-type
    out_ready = 1; in_valid = 1; in_instr = 32'hFFF00093;
    step(); in_valid = 0;
    chk("i_out_valid", {31'b0, out_valid}, 32'd1);
    chk("i_out_imm", out_imm, 32'hFFFFFFFF);
    chk("i_out_immsrc", {29'b0, out_immsrc}, 32'd0);
    step();
    chk("i_imm_count", {16'b0, imm_count}, 32'd1);

    // Fill with S then B while stalled, then drain in order
    out_ready = 0; in_valid = 1; in_instr = 32'h00112623;
    step(); in_instr = 32'hFE000EE3;
    step(); in_valid = 0;
    chk("sb_in_ready_full", {31'b0, in_ready}, 32'd0);
    chk("sb_head_s", out_imm, 32'd12);
    out_ready = 1;
    step();
    chk("sb_head_b", out_imm, 32'hFFFFFFFC);
    chk("sb_immsrc_b", {29'b0, out_immsrc}, 32'd2);
    step();
    chk("sb_empty", {31'b0, out_valid}, 32'd0);
    chk("sb_imm_count", {16'b0, imm_count}, 32'd3);

    // Back-to-back mixed stream, 8 of 10 carry an immediate
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_instr = stream[i];
      step();
      chk("st_no_bubble", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 0;
    step(); step();
    chk("st_imm_count", {16'b0, imm_count}, 32'd11);

    // R-type then illegal opcode
    in_valid = 1; in_instr = 32'h002081B3;
    step(); in_instr = 32'h0000007F;
    chk("r_has_imm", {31'b0, out_has_imm}, 32'd0);
    chk("r_imm", out_imm, 32'd0);
    step(); in_valid = 0;
    chk("ill_flag", {31'b0, out_illegal}, 32'd1);
    step();
    chk("r_ill_count", {16'b0, imm_count}, 32'd11);

    // Flush a full FIFO with in_valid and out_ready both high
    out_ready = 0; in_valid = 1; in_instr = 32'hFFF00093;
    step(); in_instr = 32'h123452B7;
    step();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1; out_ready = 1;
    step(); flush = 0; in_valid = 0;
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_imm_count", {16'b0, imm_count}, 32'd11);

    // Flush at count 1 with an accepted input that must be discarded
    out_ready = 0; in_valid = 1; in_instr = 32'h00112623;
    step(); flush = 1; in_instr = 32'hFE000EE3;
    step(); flush = 0; in_valid = 0;
    chk("fl1_out_valid", {31'b0, out_valid}, 32'd0);
    step();

    // Asynchronous reset with two entries queued
    in_valid = 1; in_instr = 32'hFFF00093;
    step(); in_instr = 32'h00112623;
    step(); in_valid = 0;
    chk("ar_pre_full", {31'b0, in_ready}, 32'd0);
    #1 reset_n = 0;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_out_imm", out_imm, 32'd0);
    chk("ar_imm_count", {16'b0, imm_count}, 32'd0);
    #2 reset_n = 1;
    step();

    // Saturating counter on the CNT_W=2 instance
    s_out_ready = 1; s_in_valid = 1; s_in_instr = 32'hFFF00093;
    for (int i = 0; i < 5; i++) step();
    s_in_valid = 0;
    step(); step(); step();
    chk("sat_imm_count", {30'b0, s_imm_count}, 32'd3);

    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
